// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a memory-wait timeout.
// Optional feature: define MULTICYCLE_CBNZ_EN to decode opcode 10110101xxx as CBNZ.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Instruction,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        UncBranch,
    output logic [1:0]  AluOp,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        PCSrc,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL,
        C_R,
        C_LDUR,
        C_STUR,
        C_CBZ,
        C_CBNZ,
        C_B
    } class_t;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    state_t     state_q, state_d;
    class_t     cls_q, dec_class;
    logic [3:0] wait_cnt;
    logic       wait_hit;
    logic       count_en;

    always_comb begin
        dec_class = C_ILLEGAL;
        casez (Instruction)
            11'b11111000010: dec_class = C_LDUR;
            11'b11111000000: dec_class = C_STUR;
            11'b10110100???: dec_class = C_CBZ;
`ifdef MULTICYCLE_CBNZ_EN
            11'b10110101???: dec_class = C_CBNZ;
`endif
            11'b000101?????: dec_class = C_B;
            11'b1??0101?000: dec_class = C_R;
            default:         dec_class = C_ILLEGAL;
        endcase
    end

    assign wait_hit = (wait_cnt == WAIT_MAX) && !mem_ready;
    assign count_en = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign state    = reset ? 3'd0 : state_q;

    // NOTE: every output and state_d gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        Reg2Loc     = 1'b0;
        ALUSrc      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        Branch      = 1'b0;
        UncBranch   = 1'b0;
        AluOp       = 2'b00;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        PCSrc       = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = S_DECODE;
                    end else if (wait_hit) begin
                        mem_timeout = 1'b1;
                    end
                end

                S_DECODE: begin
                    if (dec_class == C_ILLEGAL) begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end

                S_EXEC: begin
                    state_d = S_FETCH;
                    case (cls_q)
                        C_LDUR: begin
                            ALUSrc  = 1'b1;
                            state_d = S_MEM;
                        end
                        C_STUR: begin
                            ALUSrc  = 1'b1;
                            Reg2Loc = 1'b1;
                            state_d = S_MEM;
                        end
                        C_R: begin
                            AluOp   = 2'b10;
                            state_d = S_WB;
                        end
                        C_CBZ, C_CBNZ: begin
                            Reg2Loc = 1'b1;
                            AluOp   = 2'b01;
                            Branch  = 1'b1;
                            // CBNZ shares the CBZ path with the zero test inverted.
                            if (Zero == (cls_q == C_CBZ)) begin
                                PCWrite = 1'b1;
                                PCSrc   = 1'b1;
                            end
                        end
                        C_B: begin
                            UncBranch = 1'b1;
                            PCWrite   = 1'b1;
                            PCSrc     = 1'b1;
                            AluOp     = 2'b01;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end

                S_MEM: begin
                    if (cls_q == C_LDUR) begin
                        MemRead  = 1'b1;
                        ALUSrc   = 1'b1;
                        MemtoReg = 1'b1;
                    end else if (cls_q == C_STUR) begin
                        MemWrite = 1'b1;
                        ALUSrc   = 1'b1;
                        Reg2Loc  = 1'b1;
                    end
                    if (mem_ready) begin
                        state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
                    end else if (wait_hit) begin
                        mem_timeout = 1'b1;
                        state_d     = S_FETCH;
                    end else if (cls_q != C_LDUR && cls_q != C_STUR) begin
                        state_d = S_FETCH;
                    end
                end

                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls_q == C_LDUR);
                    state_d  = S_FETCH;
                end

                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            cls_q    <= C_ILLEGAL;
            wait_cnt <= 4'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= dec_class;
            end
            // A FETCH timeout stays in FETCH, so it must clear the counter explicitly.
            if ((state_d != state_q) || mem_timeout) begin
                wait_cnt <= 4'd0;
            end else if (count_en) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a vector table plus hand-written timeout/reset sequences,
// with expected outputs passed through a scoreboard queue.
module tb_multicycle_control;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    // Control word: {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncBranch,
    //                AluOp[1:0], PCWrite, IRWrite, PCSrc, illegal_op, mem_timeout}
    localparam logic [14:0] R2L  = 15'h4000;
    localparam logic [14:0] ASRC = 15'h2000;
    localparam logic [14:0] M2R  = 15'h1000;
    localparam logic [14:0] RW   = 15'h0800;
    localparam logic [14:0] MR   = 15'h0400;
    localparam logic [14:0] MW   = 15'h0200;
    localparam logic [14:0] BR   = 15'h0100;
    localparam logic [14:0] UB   = 15'h0080;
    localparam logic [14:0] AOPR = 15'h0040;
    localparam logic [14:0] AOPC = 15'h0020;
    localparam logic [14:0] PCW  = 15'h0010;
    localparam logic [14:0] IRW  = 15'h0008;
    localparam logic [14:0] PCS  = 15'h0004;
    localparam logic [14:0] ILL  = 15'h0002;
    localparam logic [14:0] TMO  = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;
    localparam logic [14:0] FETCH_OK = MR | IRW | PCW;

    typedef struct packed {
        logic        rst;
        logic [10:0] ins;
        logic        z;
        logic        r;
        logic [2:0]  st;
        logic [14:0] ctl;
    } vec_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [14:0] ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] Instruction;
    logic        Zero;
    logic        mem_ready;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncBranch;
    logic [1:0]  AluOp;
    logic        PCWrite, IRWrite, PCSrc, illegal_op, mem_timeout;
    logic [2:0]  state;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instruction(Instruction),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .Reg2Loc    (Reg2Loc),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .UncBranch  (UncBranch),
        .AluOp      (AluOp),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .PCSrc      (PCSrc),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input logic rst, input logic [10:0] ins, input logic z, input logic r,
                           input logic [2:0] st, input logic [14:0] ctl);
        vec_t v;
        v = '{rst: rst, ins: ins, z: z, r: r, st: st, ctl: ctl};
        vecs.push_back(v);
    endtask

    // Drive one cycle after the falling edge, queue the expectation, then compare 1 ns later.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        logic [14:0] act;
        @(negedge clk);
        reset       = v.rst;
        Instruction = v.ins;
        Zero        = v.z;
        mem_ready   = v.r;
        sb.push_back('{st: v.st, ctl: v.ctl});
        #1;
        act = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncBranch,
               AluOp, PCWrite, IRWrite, PCSrc, illegal_op, mem_timeout};
        e = sb.pop_front();
        n_vec++;
        if (state !== e.st || act !== e.ctl) begin
            n_bad++;
            $display("FAIL %s: got state=%0d ctl=%015b, expected state=%0d ctl=%015b",
                     tag, state, act, e.st, e.ctl);
        end
    endtask

    task automatic run(input string tag, input logic rst, input logic [10:0] ins, input logic z,
                       input logic r, input logic [2:0] st, input logic [14:0] ctl);
        apply('{rst: rst, ins: ins, z: z, r: r, st: st, ctl: ctl}, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        Instruction = OP_ILL;
        Zero        = 1'b0;
        mem_ready   = 1'b0;

        // Reset holds everything low.
        add_vec(1, OP_ADD,  0, 1, 3'd0, NONE);
        add_vec(1, OP_ADD,  1, 1, 3'd0, NONE);
        // ADD: 0,1,2,4
        add_vec(0, OP_ADD,  0, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_ADD,  0, 1, 3'd1, NONE);
        add_vec(0, OP_ADD,  0, 1, 3'd2, AOPR);
        add_vec(0, OP_ADD,  0, 1, 3'd4, RW);
        // LDUR, immediate ready: 5 cycles
        add_vec(0, OP_LDUR, 0, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_LDUR, 0, 1, 3'd1, NONE);
        add_vec(0, OP_LDUR, 0, 1, 3'd2, ASRC);
        add_vec(0, OP_LDUR, 0, 1, 3'd3, MR | ASRC | M2R);
        add_vec(0, OP_LDUR, 0, 1, 3'd4, RW | M2R);
        // STUR, immediate ready: 4 cycles
        add_vec(0, OP_STUR, 0, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_STUR, 0, 1, 3'd1, NONE);
        add_vec(0, OP_STUR, 0, 1, 3'd2, ASRC | R2L);
        add_vec(0, OP_STUR, 0, 1, 3'd3, MW | ASRC | R2L);
        // CBZ taken, then not taken
        add_vec(0, OP_CBZ,  1, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_CBZ,  1, 1, 3'd1, NONE);
        add_vec(0, OP_CBZ,  1, 1, 3'd2, R2L | AOPC | BR | PCW | PCS);
        add_vec(0, OP_CBZ,  0, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_CBZ,  0, 1, 3'd1, NONE);
        add_vec(0, OP_CBZ,  0, 1, 3'd2, R2L | AOPC | BR);
        // B
        add_vec(0, OP_B,    0, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_B,    0, 1, 3'd1, NONE);
        add_vec(0, OP_B,    0, 1, 3'd2, UB | PCW | PCS | AOPC);
        // Illegal opcode returns straight to FETCH
        add_vec(0, OP_ILL,  0, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_ILL,  0, 1, 3'd1, ILL);
        // CBNZ opcode
        add_vec(0, OP_CBNZ, 0, 1, 3'd0, FETCH_OK);
`ifdef MULTICYCLE_CBNZ_EN
        add_vec(0, OP_CBNZ, 0, 1, 3'd1, NONE);
        add_vec(0, OP_CBNZ, 0, 1, 3'd2, R2L | AOPC | BR | PCW | PCS);
        add_vec(0, OP_CBNZ, 1, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_CBNZ, 1, 1, 3'd1, NONE);
        add_vec(0, OP_CBNZ, 1, 1, 3'd2, R2L | AOPC | BR);
`else
        add_vec(0, OP_CBNZ, 0, 1, 3'd1, ILL);
`endif
        // LDUR with mem_ready delayed 3 cycles in MEM: 8 cycles total
        add_vec(0, OP_LDUR, 0, 1, 3'd0, FETCH_OK);
        add_vec(0, OP_LDUR, 0, 0, 3'd1, NONE);
        add_vec(0, OP_LDUR, 0, 0, 3'd2, ASRC);
        add_vec(0, OP_LDUR, 0, 0, 3'd3, MR | ASRC | M2R);
        add_vec(0, OP_LDUR, 0, 0, 3'd3, MR | ASRC | M2R);
        add_vec(0, OP_LDUR, 0, 0, 3'd3, MR | ASRC | M2R);
        add_vec(0, OP_LDUR, 0, 1, 3'd3, MR | ASRC | M2R);
        add_vec(0, OP_LDUR, 0, 0, 3'd4, RW | M2R);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // FETCH starved: 15 holding cycles, timeout on the 16th, counter restarts.
        for (int i = 0; i < 15; i++) run($sformatf("fetch_wait%0d", i), 0, OP_ADD, 0, 0, 3'd0, MR);
        run("fetch_timeout", 0, OP_ADD, 0, 0, 3'd0, MR | TMO);
        // Same count again, but ready arrives on the 16th cycle and wins.
        for (int i = 0; i < 15; i++) run($sformatf("fetch_rewait%0d", i), 0, OP_ADD, 0, 0, 3'd0, MR);
        run("fetch_ready_wins", 0, OP_ADD, 0, 1, 3'd0, FETCH_OK);
        run("add_decode", 0, OP_ADD, 0, 0, 3'd1, NONE);
        run("add_exec",   0, OP_ADD, 0, 0, 3'd2, AOPR);
        run("add_wb",     0, OP_ADD, 0, 0, 3'd4, RW);

        // LDUR starved in MEM: timeout returns to FETCH instead of WB.
        run("ld_fetch",  0, OP_LDUR, 0, 1, 3'd0, FETCH_OK);
        run("ld_decode", 0, OP_LDUR, 0, 0, 3'd1, NONE);
        run("ld_exec",   0, OP_LDUR, 0, 0, 3'd2, ASRC);
        for (int i = 0; i < 15; i++) run($sformatf("ld_mem_wait%0d", i), 0, OP_LDUR, 0, 0, 3'd3, MR | ASRC | M2R);
        run("ld_mem_timeout", 0, OP_LDUR, 0, 0, 3'd3, MR | ASRC | M2R | TMO);

        // Reset during STUR MEM: MemWrite drops immediately, FETCH follows deassertion.
        run("st_fetch",      0, OP_STUR, 0, 1, 3'd0, FETCH_OK);
        run("st_decode",     0, OP_STUR, 0, 0, 3'd1, NONE);
        run("st_exec",       0, OP_STUR, 0, 0, 3'd2, ASRC | R2L);
        run("st_mem",        0, OP_STUR, 0, 0, 3'd3, MW | ASRC | R2L);
        run("st_mem_reset",  1, OP_STUR, 0, 0, 3'd0, NONE);
        run("post_reset_fetch", 0, OP_STUR, 0, 1, 3'd0, FETCH_OK);
        run("post_reset_decode", 0, OP_STUR, 0, 0, 3'd1, NONE);

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, the maximum number of wait cycles for mem_ready before timeout; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Instruction, input, 11, opcode field [31:21] from the datapath IR.
REQ-005 SHALL have port Zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory transfer-complete handshake.
REQ-007 SHALL have outputs Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncBranch, each 1 bit, with the standard LEGv8 datapath meaning.
REQ-008 SHALL have output AluOp, 2 bits: 00 add, 01 pass/compare, 10 R-type funct decode.
REQ-009 SHALL have outputs PCWrite and IRWrite, each 1 bit: PC load enable and IR load enable.
REQ-010 SHALL have output PCSrc, 1 bit: 0 selects PC+4, 1 selects branch target.
REQ-011 SHALL have outputs illegal_op and mem_timeout, each 1 bit, each a one-cycle pulse.
REQ-012 SHALL have output state, 3 bits: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

Function
REQ-013 SHALL decode the following classes in DECODE: LDUR=11111000010, STUR=11111000000, CBZ=10110100xxx, B=000101xxxxx, R=1xx0101x000. The class SHALL be latched in a register. Any other opcode SHALL be ILLEGAL.
REQ-014 SHALL drive all outputs combinationally from state, latched class, Zero, mem_ready and the wait counter. Any output not named for a state SHALL be 0.
REQ-015 FETCH SHALL assert MemRead. While mem_ready=1 it SHALL assert IRWrite and PCWrite (PCSrc=0) and go to DECODE; otherwise it SHALL hold.
REQ-016 DECODE SHALL last exactly 1 cycle. LDUR, STUR, CBZ, B and R SHALL go to EXEC. ILLEGAL SHALL pulse illegal_op and go to FETCH.
REQ-017 EXEC for LDUR/STUR SHALL set ALUSrc=1 and AluOp=00, go to MEM, and set Reg2Loc=1 for STUR.
REQ-018 EXEC for R SHALL set AluOp=10 and go to WB.
REQ-019 EXEC for CBZ SHALL set Reg2Loc=1, AluOp=01 and Branch=1. If Zero=1 it SHALL assert PCWrite with PCSrc=1. It SHALL go to FETCH.
REQ-020 EXEC for B SHALL set UncBranch=1, PCWrite=1, PCSrc=1 and AluOp=01, then go to FETCH.
REQ-021 MEM for LDUR SHALL assert MemRead, ALUSrc and MemtoReg, and go to WB on mem_ready.
REQ-022 MEM for STUR SHALL assert MemWrite, ALUSrc and Reg2Loc, and go to FETCH on mem_ready.
REQ-023 WB SHALL assert RegWrite for 1 cycle, set MemtoReg=1 only for LDUR, and go to FETCH.
REQ-024 A 4-bit wait counter SHALL increment each cycle spent in FETCH or MEM with mem_ready=0, and SHALL clear on any state change.
REQ-025 When the counter equals MEM_WAIT_MAX and mem_ready=0, the block SHALL pulse mem_timeout and go to FETCH with no PCWrite and no IRWrite; a store SHALL be abandoned.
REQ-026 If mem_ready=1 in the same cycle the counter reaches MEM_WAIT_MAX, mem_ready SHALL win and no timeout SHALL occur.
REQ-027 Instruction latency (cycles with mem_ready immediate) SHALL be: R 4, LDUR 5, STUR 4, CBZ 3, B 3.

Reset
REQ-028 While reset=1, all outputs SHALL be 0, except state, which SHALL be 0.
REQ-029 On the first edge with reset=1, state SHALL become FETCH, the counter 0 and the latched class ILLEGAL. This SHALL hold mid-operation, including during an in-progress MEM write.
REQ-030 FETCH SHALL begin on the first cycle after reset deasserts.

Configuration
REQ-031 With macro MULTICYCLE_CBNZ_EN defined, opcode 10110101xxx SHALL decode as CBNZ: identical to CBZ except PCWrite asserts when Zero=0. Without the macro, that opcode SHALL be ILLEGAL.

Verification
REQ-032 ADD (10001011000), mem_ready=1 -> states 0,1,2,4,0; RegWrite=1 only in WB; AluOp=10 in EXEC.
REQ-033 LDUR with mem_ready delayed 3 cycles in MEM -> 3 MEM hold cycles with MemRead=1, then WB with RegWrite=1 and MemtoReg=1; total 8 cycles.
REQ-034 CBZ with Zero=1 -> PCWrite=1 and PCSrc=1 in EXEC. CBZ with Zero=0 -> PCWrite=0. Both return to FETCH next.
REQ-035 mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> mem_timeout pulses in the 16th FETCH cycle; IRWrite never asserts. Repeat with mem_ready=1 on that cycle -> no timeout.
REQ-036 Opcode 10110101000 -> CBNZ behaviour with MULTICYCLE_CBNZ_EN defined; illegal_op pulse in DECODE without it.
REQ-037 reset asserted during STUR MEM -> MemWrite drops to 0 that cycle; FETCH follows deassertion.
